// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The baud generator uses the same OVERSAMPLE constant so tick rate and bit length stay consistent.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchroniser for the asynchronous RX pin.
// Resets to 1 so the line reads as idle while RESET is asserted.
module sync_2ff (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 16x oversampled start/data/stop sampling with done/frame-error strobes.
// Define UART_PARITY_EN to add a parity bit between data and stop, plus the PARITY_ERR output.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
`ifdef UART_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 TICK,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA_OUT,
    output logic                 RX_DONE,
    output logic                 FRAME_ERR
`ifdef UART_PARITY_EN
    ,
    output logic                 PARITY_ERR
`endif
);

    localparam int CW = $clog2((SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE);
    localparam logic [CW-1:0] MID_CNT  = CW'(MID_SAMPLE);
    localparam logic [CW-1:0] BIT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICKS - 1);
    localparam logic [2:0]    N_LAST   = 3'(DATA_BITS - 1);

    state_t               state;
    logic [CW-1:0]        s_cnt;
    logic [2:0]           n_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
`ifdef UART_PARITY_EN
    logic                 perr_q;
`endif

    sync_2ff u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (RX),
        .q     (rx_s)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            s_cnt      <= '0;
            n_cnt      <= '0;
            // NOTE: the shift register is reset as well, so a partial frame can never leak into DATA_OUT.
            shreg      <= '0;
            DATA_OUT   <= '0;
            RX_DONE    <= 1'b0;
            FRAME_ERR  <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q     <= 1'b0;
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the pre-edge register values.
            RX_DONE   <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef UART_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (TICK) begin
                        if (s_cnt == MID_CNT) begin
                            s_cnt <= '0;
                            n_cnt <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (TICK) begin
                        if (s_cnt == BIT_LAST) begin
                            s_cnt <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (n_cnt == N_LAST) begin
`ifdef UART_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (TICK) begin
                        if (s_cnt == BIT_LAST) begin
                            s_cnt  <= '0;
                            perr_q <= ^shreg ^ rx_s ^ 1'(PARITY_ODD);
                            state  <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (TICK) begin
                        if (s_cnt == SB_LAST) begin
                            s_cnt <= '0;
                            if (rx_s) begin
                                DATA_OUT <= shreg;
                                RX_DONE  <= 1'b1;
`ifdef UART_PARITY_EN
                                PARITY_ERR <= perr_q;
`endif
                                state    <= IDLE;
                            end else begin
                                FRAME_ERR <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                // A line held low after a bad stop bit must go high before another start is accepted.
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus random frames against a frame-level model.
// Parity cases are included when UART_PARITY_EN is defined.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int TB_PARITY_ODD = 0;

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       perr;
    } ev_t;

    logic       CLK;
    logic       RESET;
    logic       TICK;
    logic       RX;
    logic [7:0] DATA_OUT;
    logic       RX_DONE;
    logic       FRAME_ERR;
    logic       par_err_w;

    int errors = 0;
    int checks = 0;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] exp_dout;
    logic       prev_done;
    logic       prev_ferr;

    uart_rx_ctrl u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .TICK      (TICK),
        .RX        (RX),
        .DATA_OUT  (DATA_OUT),
        .RX_DONE   (RX_DONE),
`ifdef UART_PARITY_EN
        .FRAME_ERR (FRAME_ERR),
        .PARITY_ERR(par_err_w)
`else
        .FRAME_ERR (FRAME_ERR)
`endif
    );

`ifndef UART_PARITY_EN
    assign par_err_w = 1'b0;
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        TICK = 1'b0;
        forever begin
            repeat (3) @(negedge CLK);
            TICK = 1'b1;
            @(negedge CLK);
            TICK = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: records every event and checks pulse width / exclusivity.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (RX_DONE) begin
                check("done_width", prev_done, 1'b0);
                check("done_ferr_excl", FRAME_ERR, 1'b0);
                obs_q.push_back('{1'b1, DATA_OUT, par_err_w});
            end
            if (FRAME_ERR) begin
                check("ferr_width", prev_ferr, 1'b0);
                obs_q.push_back('{1'b0, 8'h00, 1'b0});
            end
            if (par_err_w && !RX_DONE) check("perr_outside_done", par_err_w, 1'b0);
        end
        prev_done = RX_DONE;
        prev_ferr = FRAME_ERR;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge CLK); while (TICK !== 1'b1);
        end
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        wait_ticks(OVERSAMPLE);
    endtask

    // Frame-level model: a good stop yields the byte (and parity verdict), a bad stop yields a frame error.
    task automatic expect_frame(input logic [7:0] data, input logic stop_ok, input logic pbit);
        logic perr;
`ifdef UART_PARITY_EN
        perr = ((($countones(data) + pbit) % 2) != TB_PARITY_ODD);
`else
        perr = 1'b0;
`endif
        if (stop_ok) begin
            exp_q.push_back('{1'b1, data, perr});
            exp_dout = data;
        end else begin
            exp_q.push_back('{1'b0, 8'h00, 1'b0});
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_ok, input logic pbit);
        expect_frame(data, stop_ok, pbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop_ok);
    endtask

    task automatic drain(input string tag);
        RX = 1'b1;
        wait_ticks(OVERSAMPLE);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_kind"}, obs_q[i].done, exp_q[i].done);
            if (exp_q[i].done) begin
                check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
                check({tag, "_perr"}, obs_q[i].perr, exp_q[i].perr);
            end
        end
        check({tag, "_dout"}, DATA_OUT, exp_dout);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rd;
        logic       rok;
        logic       rpb;
        logic [7:0] partial;

        RESET     = 1'b1;
        RX        = 1'b1;
        exp_dout  = 8'h00;
        prev_done = 1'b0;
        prev_ferr = 1'b0;
        partial   = 8'h12;

        #22;
        check("rst_dout", DATA_OUT, 8'h00);
        check("rst_done", RX_DONE, 1'b0);
        check("rst_ferr", FRAME_ERR, 1'b0);
        check("rst_state", u_dut.state, IDLE);
        @(negedge CLK);
        RESET = 1'b0;
        wait_ticks(4);

        send_frame(8'hA5, 1'b1, 1'b0);
        drain("a5");

        // Short low glitch must be rejected at the start-bit midpoint.
        RX = 1'b0;
        wait_ticks(4);
        RX = 1'b1;
        wait_ticks(16);
        send_frame(8'h3C, 1'b1, 1'b0);
        drain("glitch_3c");

        rd = 8'($urandom);
        send_frame(rd, 1'b0, 1'b0);
        wait_ticks(20 * OVERSAMPLE);
        drain("break");
        send_frame(8'h5A, 1'b1, 1'b0);
        drain("after_break");

        // Reset in the middle of data bit 4, then abandon the frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        RX = partial[4];
        wait_ticks(8);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        RX    = 1'b1;
        #1;
        exp_dout = 8'h00;
        check("async_rst_dout", DATA_OUT, 8'h00);
        check("async_rst_state", u_dut.state, IDLE);
        check("async_rst_done", RX_DONE, 1'b0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        drain("rst_partial");
        send_frame(8'hFF, 1'b1, 1'b0);
        drain("after_rst_ff");

        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        drain("back2back");

`ifdef UART_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drain("par_ok");
        send_frame(8'h07, 1'b1, 1'b0);
        drain("par_bad");
`endif

        for (int n = 0; n < 10; n++) begin
            rd  = 8'($urandom);
            rok = ($urandom_range(3) != 0);
            rpb = 1'($urandom);
            send_frame(rd, rok, rpb);
            if (!rok) wait_ticks($urandom_range(48, 16));
            RX = 1'b1;
            wait_ticks($urandom_range(3));
            drain("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
